// File: rtl/conv_scan_ctrl.sv
// conv_scan_ctrl: raster-scan sequencer feeding the 3x3 window collector.
// Zero padding ('same' convolution) is compiled in when CONV_ZERO_PAD_EN is defined.
module conv_scan_ctrl #(
    parameter int IMAGE_WIDTH  = 128,
    parameter int IMAGE_HEIGHT = 128
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [7:0]  cfg_width,
    input  logic [7:0]  cfg_height,
    output logic        busy,
    output logic        done,
    output logic        cfg_err,
    output logic        rd_en,
    output logic [15:0] rd_addr,
    input  logic [7:0]  rd_data,
    output logic [7:0]  pixel_out,
    output logic [7:0]  stage_width,
    output logic        win_valid,
    output logic [7:0]  win_row,
    output logic [7:0]  win_col
);

    // state   | meaning
    // S_IDLE  | waiting for start; cfg checked here
    // S_SCAN  | one grid position issued per cycle
    // S_DRAIN | last pixel presented, done pulsed
    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DRAIN} state_t;

`ifdef CONV_ZERO_PAD_EN
    localparam logic [7:0] PAD = 8'd2;
`else
    localparam logic [7:0] PAD = 8'd0;
`endif

    state_t      state, state_nxt;
    logic [7:0]  ws_q, hs_q, row_q, col_q, prow_q, pcol_q;
    logic [15:0] addr_q;
    logic        iss_q, cfg_err_q;
    logic        start_ok, start_bad, cfg_legal, last_pos, border, pad_q;
    logic [8:0]  w_scan;

    assign w_scan    = {1'b0, cfg_width} + {1'b0, PAD};
    assign cfg_legal = (cfg_width >= 8'd3) && (cfg_height >= 8'd3) &&
                       (w_scan <= 9'(IMAGE_WIDTH)) &&
                       ({1'b0, cfg_height} <= 9'(IMAGE_HEIGHT));
    assign last_pos  = (row_q == hs_q - 8'd1) && (col_q == ws_q - 8'd1);

`ifdef CONV_ZERO_PAD_EN
    assign border = (row_q == 8'd0) || (row_q == hs_q - 8'd1) ||
                    (col_q == 8'd0) || (col_q == ws_q - 8'd1);

    // Pad flag idles high so pixel_out reads as zero outside a frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pad_q <= 1'b1;
        else        pad_q <= !rd_en;
    end
`else
    assign border = 1'b0;
    assign pad_q  = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        start_ok  = 1'b0;
        start_bad = 1'b0;
        busy      = 1'b0;
        rd_en     = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start && !abort) begin
                    if (cfg_legal) begin
                        state_nxt = S_SCAN;
                        start_ok  = 1'b1;
                    end else begin
                        start_bad = 1'b1;
                    end
                end
            end
            S_SCAN: begin
                busy  = !abort;
                rd_en = !abort && !border;
                if (abort)         state_nxt = S_IDLE;
                else if (last_pos) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                busy      = !abort;
                done      = !abort;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ws_q      <= 8'd0;
            hs_q      <= 8'd0;
            row_q     <= 8'd0;
            col_q     <= 8'd0;
            addr_q    <= 16'd0;
            iss_q     <= 1'b0;
            prow_q    <= 8'd0;
            pcol_q    <= 8'd0;
            cfg_err_q <= 1'b0;
        end else begin
            cfg_err_q <= start_bad;
            iss_q     <= (state == S_SCAN) && !abort;
            prow_q    <= row_q;
            pcol_q    <= col_q;
            if (start_ok) begin
                ws_q   <= cfg_width + PAD;
                hs_q   <= cfg_height + PAD;
                row_q  <= 8'd0;
                col_q  <= 8'd0;
                addr_q <= 16'd0;
            end else if ((state == S_SCAN) && !abort) begin
                if (col_q == ws_q - 8'd1) begin
                    col_q <= 8'd0;
                    row_q <= row_q + 8'd1;
                end else begin
                    col_q <= col_q + 8'd1;
                end
                if (rd_en) addr_q <= addr_q + 16'd1;
            end
        end
    end

    // Windows need two full grid rows in the collector, so stale lines never flag.
    assign win_valid   = iss_q && !abort && (prow_q >= 8'd2) && (pcol_q >= 8'd2);
    assign win_row     = win_valid ? prow_q - 8'd2 : 8'd0;
    assign win_col     = win_valid ? pcol_q - 8'd2 : 8'd0;
    assign pixel_out   = pad_q ? 8'd0 : rd_data;
    assign rd_addr     = addr_q;
    assign stage_width = ws_q;
    assign cfg_err     = cfg_err_q;

endmodule

// File: doc/conv_scan_ctrl.md
# conv_scan_ctrl

Raster-scan sequencer for the 3x3 window collector in the convolution datapath. On `start` it reads one stage feature map from the activation buffer, one pixel per cycle, at fixed 1-cycle read latency. It drives the collector's `pixel_in` and `stage_width`, and flags which collector outputs form a complete in-image 3x3 window. Optional zero padding turns 'valid' convolution into 'same' convolution.

## Interface
Parameters:
- `IMAGE_WIDTH`, 128: max stage width; must match the collector instance.
- `IMAGE_HEIGHT`, 128: max stage height.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  begin frame; sampled only in IDLE.
- `abort`  in  1  synchronous frame abort.
- `cfg_width`  in  8  stage width W in pixels; latched at start.
- `cfg_height`  in  8  stage height H in pixels; latched at start.
- `busy`  out  1  frame in progress.
- `done`  out  1  1-cycle pulse, coincident with the last `win_valid`.
- `cfg_err`  out  1  1-cycle pulse when `start` is rejected.
- `rd_en`  out  1  activation buffer read strobe.
- `rd_addr`  out  16  buffer address, `row*W + col`.
- `rd_data`  in  8  read data, valid the cycle after `rd_en`.
- `pixel_out`  out  8  to collector `pixel_in`.
- `stage_width`  out  8  to collector `stage_width`.
- `win_valid`  out  1  collector outputs hold a valid window this cycle.
- `win_row`, `win_col`  out  8 each  output-map coordinate of the current window.

## Operation
- FSM states:
  - IDLE: `start` with legal cfg → SCAN; illegal cfg → stays in IDLE and pulses `cfg_err`.
  - SCAN: issues one scan position per cycle; after the last position → DRAIN.
  - DRAIN: one cycle; presents the final pixel, pulses `done` → IDLE.
- Legal cfg: 3 ≤ W ≤ `IMAGE_WIDTH`, 3 ≤ H ≤ `IMAGE_HEIGHT`; with padding, W+2 ≤ `IMAGE_WIDTH`.
- Scan grid is Ws×Hs, visited row-major with `col` innermost.
  - No padding: Ws=W, Hs=H.
  - Padding: Ws=W+2, Hs=H+2.
- Per SCAN cycle at grid position (r,c):
  - Interior position (all positions without padding): `rd_en`=1 and `rd_addr` = next sequential address. The address is kept as a running counter, with no multiplier; it starts at 0 and increments only on reads.
  - Border position (padding only): `rd_en`=0 and a registered pad flag is set.
- `pixel_out` = pad flag ? 0 : `rd_data`. It is combinational from the registered flag and is valid one cycle after issue.
- `stage_width` = latched Ws, held constant from start until the next start; 0 after reset.
- `win_valid` is asserted in the `pixel_out` cycle of grid position (r,c) when r≥2 and c≥2.
  - `win_row` = r−2, `win_col` = c−2. Both are 0 when `win_valid` is low.
  - No windows are flagged before two full grid rows have entered the collector, so stale line-buffer data from a previous frame is never marked valid.
- Window count per frame: (H−2)(W−2) without padding, H·W with padding.
- `abort` in SCAN or DRAIN → IDLE on the next edge. In that same cycle `rd_en`, `win_valid` and `busy` go low, and no `done` is issued. `abort` has priority over `start`.
- `start` while busy is ignored.
- The downstream MAC must accept every `win_valid`; there is no backpressure, because the collector shifts every cycle.

## Timing
- Reset values: `busy`, `done`, `cfg_err`, `rd_en`, `win_valid` = 0; `rd_addr`, `win_row`, `win_col`, `stage_width` = 0; `pixel_out` = 0 (pad flag resets to 1).
- Let edge E0 be the edge that samples `start`. Then:
  - Issue occurs in cycles 1..N, where N = Ws·Hs.
  - `pixel_out` is valid in cycles 2..N+1.
  - DRAIN is cycle N+1; `done` and the last `win_valid` occur in cycle N+1.
  - `busy` is high in cycles 1..N+1.
  - A new `start` can be accepted at the edge ending cycle N+1's successor (IDLE in cycle N+2).
- Latency from `rd_en` to `pixel_out` and `win_valid` is 1 cycle.
- `cfg_err` is asserted in cycle 1 only.
- Counter wrap: `col` wraps Ws−1→0 with `row`+1; `row` reaching Hs−1 at `col` Ws−1 ends SCAN.

## Configuration
- `CONV_ZERO_PAD_EN`:
  - Defined: padding grid as above, giving 'same' output of H×W; legal W ≤ `IMAGE_WIDTH`−2.
  - Undefined: pad logic is not compiled; every scan cycle reads, giving 'valid' output of (H−2)×(W−2); pad flag is constant 0; `pixel_out` = `rd_data`.

## Test plan
- No pad, W=4, H=3: `rd_addr` is 0..11 in cycles 1..12; `win_valid` is high in cycles 12–13 with (row,col)=(0,0),(0,1); `done` in cycle 13; `busy` in cycles 1–13.
- Pad, W=3, H=3: 25 scan cycles; 9 `rd_en` pulses with addresses 0..8; `pixel_out`=0 at border positions; 9 windows (0,0)..(2,2); `done` in cycle 26.
- `cfg_width`=2 or `cfg_height`=200 with `start`: `cfg_err` pulse in cycle 1; `busy`, `rd_en` and `done` stay 0.
- `abort` in cycle 5 of a W=4, H=4 frame: IDLE by cycle 6; no `done`; an immediate restart yields a full, correct 4-window frame with no stale windows.
- `start` pulsed while busy: ignored, and the frame completes unchanged. `rst_n` low mid-frame: all outputs at reset values asynchronously.
- Back-to-back frames with W=5 then W=3: `stage_width` switches 5→3 in the cycle after the second `start`; window coordinates restart at (0,0).
